ha_ow_reader: RTL and testbench

- Output-side reader for the 32-bit token stream that leaves a DSE solution through its output wrapper.
- Accepts words over a valid/ready handshake into a parameterised FIFO and serves them to a host read port.
- Counts accepted tokens against a programmed expected count, then signals completion.
- Sits at the top level, opposite the input wrapper, so the bench or host can collect a solution's results.

---
 rtl/ha_ow_reader.sv | 165 ++++++++++++++++
 tb/tb_ha_ow_reader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ha_ow_reader.sv
// ha_ow_reader: collects the 32-bit token stream leaving a DSE output wrapper.
// Words enter through a valid/ready handshake into a small FIFO and are served
// to the host through a registered, one-cycle-latency read port. A programmed
// token count decides when collection ends; done rises once the FIFO drains.
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready.
// in_ready depends only on registered state (FSM state and FIFO level), so the
// producer may hold in_valid and in_data until the transfer edge without any
// combinational loop through this block.
module ha_ow_reader #(
    parameter int DataIn_1_BW = 32,
    parameter int DEPTH       = 8,
    parameter int CNT_BW      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [CNT_BW-1:0]         exp_cnt,
    input  logic                      in_valid,
    input  logic [DataIn_1_BW-1:0]    in_data,
    output logic                      in_ready,
    input  logic                      rd_en,
    output logic [DataIn_1_BW-1:0]    rd_data,
    output logic                      rd_valid,
    output logic [$clog2(DEPTH):0]    level,
    output logic [CNT_BW-1:0]         rx_cnt,
    output logic                      done,
    output logic                      rd_err
);

    localparam int AW     = $clog2(DEPTH);
    localparam int LVL_BW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [LVL_BW-1:0]       level_q, level_d;
    logic [CNT_BW-1:0]       rx_cnt_q, rx_cnt_d;
    logic [CNT_BW-1:0]       target_q, target_d;
    logic [DataIn_1_BW-1:0]  rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    rd_err_q, rd_err_d;

    logic [DataIn_1_BW-1:0]  mem [DEPTH];

    logic                    full;
    logic                    empty;
    logic                    push;
    logic                    pop;
    logic [CNT_BW-1:0]       rx_cnt_inc;

    assign full       = (level_q == LVL_BW'(DEPTH));
    assign empty      = (level_q == '0);
    assign in_ready   = (state_q == RUN) && !full;
    assign push       = in_valid && in_ready;
    // No bypass: a read of an empty FIFO is never served by a same-cycle push.
    assign pop        = rd_en && !empty;
    assign rx_cnt_inc = (rx_cnt_q == '1) ? rx_cnt_q : rx_cnt_q + 1'b1;

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign level    = level_q;
    assign rx_cnt   = rx_cnt_q;
    assign done     = (state_q == DONE);
    assign rd_err   = rd_err_q;

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    // FIFO pointers, occupancy and the registered read port.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + AW'(1);
            rd_data_d  = mem[rd_ptr_q];
            rd_valid_d = 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_BW'(1);
            2'b01:   level_d = level_q - LVL_BW'(1);
            default: level_d = level_q;
        endcase
    end

    // Collection control: start handling, token counting and drain detection.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        rx_cnt_d = rx_cnt_q;
        rd_err_d = rd_err_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    target_d = exp_cnt;
                    rx_cnt_d = '0;
                    rd_err_d = 1'b0;
                    state_d  = (exp_cnt == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (push) begin
                    rx_cnt_d = rx_cnt_inc;
                    if (rx_cnt_inc == target_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Next-state level lets the final pop finish on the same edge.
                if (level_d == '0) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A read attempt on an empty FIFO is recorded even on a start cycle.
        if (rd_en && empty) begin
            rd_err_d = 1'b1;
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rx_cnt_q   <= '0;
            target_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rx_cnt_q   <= rx_cnt_d;
            target_q   <= target_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
        end
    end

endmodule

// File: tb/tb_ha_ow_reader.sv
// Bench for ha_ow_reader: directed scenarios with a word scoreboard.
module tb_ha_ow_reader;

    localparam int W     = 32;
    localparam int DEPTH = 8;
    localparam int CBW   = 16;

    logic            clk;
    logic            rst;
    logic            start;
    logic [CBW-1:0]  exp_cnt;
    logic            in_valid;
    logic [W-1:0]    in_data;
    logic            in_ready;
    logic            rd_en;
    logic [W-1:0]    rd_data;
    logic            rd_valid;
    logic [3:0]      level;
    logic [CBW-1:0]  rx_cnt;
    logic            done;
    logic            rd_err;

    logic [W-1:0]    exp_q[$];
    int              tests_run;
    int              tests_failed;
    int              n_acc;

    ha_ow_reader #(.DataIn_1_BW(W), .DEPTH(DEPTH), .CNT_BW(CBW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .exp_cnt  (exp_cnt),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .level    (level),
        .rx_cnt   (rx_cnt),
        .done     (done),
        .rd_err   (rd_err)
    );

    // Clock and global time limit.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // One clock: record a transfer that will happen on this edge, then step.
    task automatic cycle();
        if (in_valid && in_ready) begin
            exp_q.push_back(in_data);
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [CBW-1:0] cnt);
        start   = 1'b1;
        exp_cnt = cnt;
        n_acc   = 0;
        cycle();
        start   = 1'b0;
    endtask

    // Monitor: every rd_valid word must be the oldest expected word.
    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            if (exp_q.size() == 0) begin
                check("rd_valid_unexpected", 64'(rd_data), 64'hDEAD);
            end else begin
                check("rd_data_order", 64'(rd_data), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        n_acc        = 0;
        rst      = 1'b1;
        start    = 1'b0;
        exp_cnt  = '0;
        in_valid = 1'b0;
        in_data  = '0;
        rd_en    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 0);
        check("rst_level",    64'(level),    0);
        check("rst_rx_cnt",   64'(rx_cnt),   0);
        check("rst_done",     64'(done),     0);
        check("rst_rd_err",   64'(rd_err),   0);
        check("rst_rd_valid", 64'(rd_valid), 0);
        check("rst_rd_data",  64'(rd_data),  0);
        rst = 1'b0;
        cycle();
        check("idle_in_ready", 64'(in_ready), 0);

        // Basic collect of three words.
        do_start(16'd3);
        check("basic_run_ready", 64'(in_ready), 1);
        in_valid = 1'b1;
        in_data = 32'h11111111; cycle();
        in_data = 32'h22222222; cycle();
        in_data = 32'h33333333; cycle();
        in_valid = 1'b0;
        check("basic_rx_cnt", 64'(rx_cnt), 3);
        check("basic_level", 64'(level), 3);
        check("basic_drain_ready", 64'(in_ready), 0);
        rd_en = 1'b1;
        cycle();
        check("basic_rd_valid_lat", 64'(rd_valid), 1);
        check("basic_done_early", 64'(done), 0);
        cycle();
        cycle();
        rd_en = 1'b0;
        check("basic_done", 64'(done), 1);
        check("basic_level0", 64'(level), 0);
        check("basic_rd_err", 64'(rd_err), 0);
        cycle();
        check("basic_rd_valid_idle", 64'(rd_valid), 0);
        check("basic_rd_data_hold", 64'(rd_data), 64'h33333333);

        // Backpressure at full.
        do_start(16'd10);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 32'hA0000000 + 32'(n_acc);
            cycle();
        end
        check("bp_level_full", 64'(level), 8);
        check("bp_ready_full", 64'(in_ready), 0);
        check("bp_rx_8", 64'(rx_cnt), 8);
        for (int k = 0; k < 2; k++) begin
            rd_en = 1'b1;
            cycle();
            rd_en = 1'b0;
            check("bp_ready_after_pop", 64'(in_ready), 1);
            check("bp_level_after_pop", 64'(level), 7);
            in_data = 32'hA0000000 + 32'(n_acc);
            cycle();
            check("bp_level_refill", 64'(level), 8);
            check("bp_ready_refill", 64'(in_ready), 0);
        end
        check("bp_rx_10", 64'(rx_cnt), 10);
        in_valid = 1'b0;
        rd_en = 1'b1;
        repeat (8) cycle();
        rd_en = 1'b0;
        check("bp_done", 64'(done), 1);
        check("bp_level0", 64'(level), 0);

        // Simultaneous push and pop across pointer wrap.
        do_start(16'd9);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'hB0000000 + 32'(n_acc);
            cycle();
        end
        check("sim_level4", 64'(level), 4);
        rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 32'hB0000000 + 32'(n_acc);
            cycle();
            check("sim_level_steady", 64'(level), 4);
        end
        in_valid = 1'b0;
        check("sim_rx9", 64'(rx_cnt), 9);
        check("sim_drain_ready", 64'(in_ready), 0);
        repeat (4) cycle();
        rd_en = 1'b0;
        check("sim_done", 64'(done), 1);

        // Zero count and empty read.
        do_start(16'd0);
        check("zero_ready", 64'(in_ready), 0);
        check("zero_not_done", 64'(done), 0);
        cycle();
        check("zero_done", 64'(done), 1);
        check("zero_ready2", 64'(in_ready), 0);
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        check("empty_rd_valid", 64'(rd_valid), 0);
        check("empty_rd_err", 64'(rd_err), 1);
        cycle();
        check("rd_err_sticky", 64'(rd_err), 1);
        do_start(16'd0);
        check("rd_err_clear", 64'(rd_err), 0);
        cycle();

        // Asynchronous reset in the middle of a run.
        do_start(16'd6);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'hC0000000 + 32'(n_acc);
            cycle();
        end
        in_valid = 1'b0;
        check("ar_level_pre", 64'(level), 3);
        #2;
        rst = 1'b1;
        #1;
        check("ar_level", 64'(level), 0);
        check("ar_rx_cnt", 64'(rx_cnt), 0);
        check("ar_done", 64'(done), 0);
        check("ar_in_ready", 64'(in_ready), 0);
        check("ar_rd_data", 64'(rd_data), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b1;
        in_data = 32'hEEEEEEEE;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("ar_refuse_ready", 64'(in_ready), 0);
            check("ar_refuse_level", 64'(level), 0);
        end
        in_valid = 1'b0;

        // Finish a two-word run, then restart from DONE with one word.
        do_start(16'd2);
        in_valid = 1'b1;
        in_data = 32'hD0000001; cycle();
        in_data = 32'hD0000002; cycle();
        in_valid = 1'b0;
        rd_en = 1'b1;
        repeat (2) cycle();
        rd_en = 1'b0;
        check("rs_done_first", 64'(done), 1);
        check("rs_rx2", 64'(rx_cnt), 2);
        do_start(16'd1);
        check("rs_rx_clear", 64'(rx_cnt), 0);
        check("rs_done_fall", 64'(done), 0);
        check("rs_ready", 64'(in_ready), 1);
        in_valid = 1'b1;
        in_data = 32'hD0000003;
        cycle();
        in_valid = 1'b0;
        check("rs_rx1", 64'(rx_cnt), 1);
        check("rs_ready_off", 64'(in_ready), 0);
        check("rs_not_done", 64'(done), 0);
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        check("rs_done", 64'(done), 1);
        cycle();

        check("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
